// File: rtl/cl_dram_perf_pkg.sv
// Shared definitions for the DRAM performance block: CSR offsets, AXI response
// codes and the CSR slave FSM state types.
package cl_dram_perf_pkg;

    localparam logic [5:0] CSR_CTRL       = 6'h00;
    localparam logic [5:0] CSR_STATUS     = 6'h04;
    localparam logic [5:0] CSR_ADDR_LO    = 6'h08;
    localparam logic [5:0] CSR_ADDR_HI    = 6'h0C;
    localparam logic [5:0] CSR_NUM_BURSTS = 6'h10;
    localparam logic [5:0] CSR_CYCLES     = 6'h14;
    localparam logic [5:0] CSR_SCRATCH    = 6'h18;
    localparam logic [5:0] CSR_MAP_END    = 6'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_csr_slave_if.sv
// AXI-Lite bus bundle. The "master" modport is the view taken by the CSR slave
// (address/data in, ready/response out); "slave" is the opposite side.
interface axi_lite_bus_t;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_csr_slave.sv
// AXI-Lite CSR slave for the DRAM traffic generator: config registers, start /
// soft-reset pulses and status/cycle-count readback.
import cl_dram_perf_pkg::*;

module axi_lite_csr_slave #(
    parameter logic [31:0] ADDR_LSB    = 32'h0000_0000,
    parameter logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_lite_bus_t.master        bus,
    output logic                 start_pulse,
    output logic                 soft_rst_pulse,
    output logic [63:0]          cfg_addr,
    output logic [31:0]          cfg_num_bursts,
    input  logic                 busy_i,
    input  logic                 done_i,
    input  logic [31:0]          cycle_count_i
);

    wr_state_t   wstate, wstate_n;
    rd_state_t   rstate, rstate_n;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    logic [31:0] addr_lo, addr_hi, num_bursts, scratch;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] wr_addr, wr_data, wr_off, rd_off, rd_value;
    logic [3:0]  wr_strb;
    logic        wr_mapped, rd_mapped;
    logic [5:0]  wr_reg, rd_reg;
    logic [1:0]  rd_resp;

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata;
    assign bus.rresp   = rresp;

    assign cfg_addr       = {addr_hi, addr_lo};
    assign cfg_num_bursts = num_bursts;

    assign aw_hs = bus.awvalid && awready;
    assign w_hs  = bus.wvalid && wready;
    assign ar_hs = bus.arvalid && arready;

    // A channel arriving this cycle bypasses its holding register so the commit
    // can happen on the same edge as the later of the two handshakes.
    assign wr_addr = aw_held ? aw_addr_q : bus.awaddr;
    assign wr_data = w_held  ? w_data_q  : bus.wdata;
    assign wr_strb = w_held  ? w_strb_q  : bus.wstrb;
    assign commit  = (wstate == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_off    = wr_addr - ADDR_LSB;
    assign wr_mapped = wr_off < {26'd0, CSR_MAP_END};
    assign wr_reg    = {wr_off[5:2], 2'b00};

    assign rd_off    = bus.araddr - ADDR_LSB;
    assign rd_mapped = rd_off < {26'd0, CSR_MAP_END};
    assign rd_reg    = {rd_off[5:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wstate <= W_IDLE;
        else        wstate <= wstate_n;
    end

    always_comb begin
        wstate_n = wstate;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        case (wstate)
            W_IDLE: begin
                awready = !aw_held;
                wready  = !w_held;
                if (commit) wstate_n = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bus.bready) wstate_n = W_IDLE;
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= bus.awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bresp          <= RESP_OKAY;
            start_pulse    <= 1'b0;
            soft_rst_pulse <= 1'b0;
            addr_lo        <= '0;
            addr_hi        <= '0;
            num_bursts     <= '0;
            scratch        <= '0;
        end else begin
            start_pulse    <= 1'b0;
            soft_rst_pulse <= 1'b0;
            if (commit) begin
                bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (wr_mapped) begin
                    case (wr_reg)
                        CSR_CTRL: begin
                            if (wr_strb[0]) begin
                                start_pulse    <= wr_data[0] && !busy_i;
                                soft_rst_pulse <= wr_data[1];
                            end
                        end
                        CSR_ADDR_LO:    addr_lo    <= apply_wstrb(addr_lo, wr_data, wr_strb);
                        CSR_ADDR_HI:    addr_hi    <= apply_wstrb(addr_hi, wr_data, wr_strb);
                        CSR_NUM_BURSTS: num_bursts <= apply_wstrb(num_bursts, wr_data, wr_strb);
                        CSR_SCRATCH:    scratch    <= apply_wstrb(scratch, wr_data, wr_strb);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_value = RD_ERR_DATA;
        rd_resp  = RESP_SLVERR;
        if (rd_mapped) begin
            rd_resp = RESP_OKAY;
            case (rd_reg)
                CSR_CTRL:       rd_value = '0;
                CSR_STATUS:     rd_value = {30'd0, done_i, busy_i};
                CSR_ADDR_LO:    rd_value = addr_lo;
                CSR_ADDR_HI:    rd_value = addr_hi;
                CSR_NUM_BURSTS: rd_value = num_bursts;
                CSR_CYCLES:     rd_value = cycle_count_i;
                CSR_SCRATCH:    rd_value = scratch;
                default:        rd_value = RD_ERR_DATA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstate <= R_IDLE;
        else        rstate <= rstate_n;
    end

    always_comb begin
        rstate_n = rstate;
        arready  = 1'b0;
        rvalid   = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (bus.arvalid) rstate_n = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (bus.rready) rstate_n = R_IDLE;
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    // Captured at the AR edge, so a same-edge write commit is not visible here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata <= rd_value;
            rresp <= rd_resp;
        end
    end

endmodule

// File: doc/axi_lite_csr_slave.md
# axi_lite_csr_slave

AXI-Lite register slave that terminates the host configuration bus for the DRAM performance block. Decodes word-aligned reads/writes into a small CSR map. Drives test configuration (base address, burst count, start/soft-reset pulses) into the traffic generator and returns its status and cycle count. Sits directly downstream of the AXI-Lite bus interface; one instance per bus.

## Interface
- ADDR_LSB, default 0x00: byte-address base subtracted before decode; decode uses offset[5:2].
- RD_ERR_DATA, default 32'hDEAD_BEEF: rdata returned on unmapped reads.
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- bus  modport  —  axi_lite_bus_t.master: inputs awaddr/awvalid, wdata/wstrb/wvalid, bready, araddr/arvalid, rready; outputs awready, wready, bresp/bvalid, arready, rdata/rresp/rvalid.
- start_pulse  output  1  one-cycle pulse on CTRL.start write.
- soft_rst_pulse  output  1  one-cycle pulse on CTRL.soft_rst write.
- cfg_addr  output  64  {ADDR_HI, ADDR_LO}.
- cfg_num_bursts  output  32  NUM_BURSTS register.
- busy_i  input  1  generator running.
- done_i  input  1  generator finished (level).
- cycle_count_i  input  32  generator cycle counter.

## Operation
- Register map (offset): 0x00 CTRL (WO; bit0 start, bit1 soft_rst, reads 0); 0x04 STATUS (RO; {30'b0, done_i, busy_i}); 0x08 ADDR_LO; 0x0C ADDR_HI; 0x10 NUM_BURSTS; 0x14 CYCLES (RO, cycle_count_i); 0x18 SCRATCH. All RW registers reset to 0.
- wstrb honoured per byte on RW registers. CTRL bits act only if wstrb[0]=1.
- Writes to RO registers ignored, bresp OKAY (2'b00). Writes/reads at offsets ≥ 0x1C: no effect, resp SLVERR (2'b10); reads return RD_ERR_DATA.
- start written while busy_i=1: no pulse, bresp OKAY.
- Write FSM: W_IDLE -> W_RESP -> W_IDLE.
  - In W_IDLE, AW and W are captured independently: awready=1 until AW is held, wready=1 until W is held. Either order or the same cycle is accepted.
  - Once both are held, the commit happens on that edge; the FSM enters W_RESP with bvalid=1.
  - W_RESP holds bvalid/bresp until bready; then W_IDLE with both ready lines high.
- Read FSM: R_IDLE (arready=1) -> R_DATA (rvalid=1, rdata/rresp held stable) -> R_IDLE on rready.
- Read and write channels are fully independent and may be active in the same cycle.

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, pulses=0, cfg_*=0.
- Write latency: bvalid rises the cycle after the edge on which the later of AW/W is accepted. Register update and pulse occur in that same cycle.
- Read latency: rvalid rises the cycle after the AR handshake. rdata is sampled at the handshake edge.
- Read handshake coinciding with a write commit to the same register returns the old value.
- Back-to-back throughput: 1 write per 2 cycles with bready=1; 1 read per 2 cycles with rready=1.
- Pulses last exactly 1 cycle.
- rst_n low mid-transaction: all outputs return to reset values immediately. The in-flight transaction is dropped, with no response.

## Structure
- Shared package cl_dram_perf_pkg holds:
  - register offset constants (CSR_CTRL, CSR_STATUS, ...);
  - resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10);
  - write and read FSM state enums.
- No sub-module: two small FSMs plus the register file inline, roughly 200 lines.

## Test plan
- Reset then read 0x08/0x0C/0x10/0x18 -> rdata 0, rresp OKAY, rvalid 1 cycle after AR.
- Write 0x18=0xA5A5_1234 with wstrb=4'b0101 over 0 -> readback 0x00A5_0034.
- W two cycles before AW, bready held low 3 cycles -> bvalid stays high 3 cycles; write commits once.
- Write 0x10=100, 0x08=0x1000, 0x0C=0x2, then CTRL=1 with busy_i=0:
  - cfg_num_bursts=100 and cfg_addr=0x2_0000_1000;
  - start_pulse high exactly 1 cycle.
- CTRL=1 with busy_i=1 -> no start_pulse, bresp OKAY.
- Read 0x40 -> rdata 0xDEAD_BEEF, rresp SLVERR.
- Write 0x40 -> bresp SLVERR; no register changes.
- Assert rst_n low while rvalid=1 -> rvalid=0 immediately; next read works normally.
